// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART serialiser (5..DATA_W data bits,
// none/odd/even/mark/space parity, 1/1.5/2 stop bits), timed by s_tick.
// Frame configuration is captured when a word is accepted.
// Optional: define UART_TX_CFG_CTS_EN to add an active-low cts_n input
// that gates word acceptance.
module uart_tx_cfg #(
    parameter int DATA_W = 9,
    parameter int OVS    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_tick,
`ifdef UART_TX_CFG_CTS_EN
    input  logic              cts_n,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] din,
    input  logic [3:0]        cfg_data_bits,
    input  logic [1:0]        cfg_stop,
    input  logic [2:0]        cfg_parity,
    output logic              tx,
    output logic              busy,
    output logic              tx_done_tick
);
    localparam int TW = $clog2(2 * OVS);
    localparam logic [TW-1:0] BIT_LAST    = TW'(OVS - 1);
    localparam logic [TW-1:0] STOP15_LAST = TW'(OVS + OVS / 2 - 1);
    localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [3:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        nbits_q, nbits_d;
    logic [1:0]        stop_q, stop_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              tx_q, tx_d;

    logic              cts_ok;
    logic              accept;
    logic              done_tick;
    logic [3:0]        nbits_clamp;
    logic              din_xor;
    logic              par_en_new;
    logic              par_bit_new;
    logic [TW-1:0]     stop_last;

`ifdef UART_TX_CFG_CTS_EN
    logic cts_meta_q, cts_meta_d;
    logic cts_sync_q, cts_sync_d;

    // Next values of the two-stage cts_n synchroniser.
    always_comb begin
        cts_meta_d = cts_n;
        cts_sync_d = cts_meta_q;
    end

    // Synchroniser flops; reset to "not clear to send".
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= cts_meta_d;
            cts_sync_q <= cts_sync_d;
        end
    end

    assign cts_ok = ~cts_sync_q;
`else
    assign cts_ok = 1'b1;
`endif

    assign in_ready = (state_q == IDLE) && cts_ok;
    assign accept   = in_valid && in_ready;

    // Clamp the requested data length and precompute parity from the word
    // being accepted, so only its latched low bits ever contribute.
    always_comb begin
        nbits_clamp = cfg_data_bits;
        if (cfg_data_bits < 4'd5) begin
            nbits_clamp = 4'd5;
        end else if (cfg_data_bits > 4'(DATA_W)) begin
            nbits_clamp = 4'(DATA_W);
        end
        din_xor = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (i < 32'(nbits_clamp)) begin
                din_xor = din_xor ^ din[i];
            end
        end
        par_en_new  = 1'b0;
        par_bit_new = 1'b0;
        case (cfg_parity)
            3'd1:    begin par_en_new = 1'b1; par_bit_new = ~din_xor; end
            3'd2:    begin par_en_new = 1'b1; par_bit_new = din_xor;  end
            3'd3:    begin par_en_new = 1'b1; par_bit_new = 1'b1;     end
            3'd4:    begin par_en_new = 1'b1; par_bit_new = 1'b0;     end
            default: begin par_en_new = 1'b0; par_bit_new = 1'b0;     end
        endcase
    end

    // Last tick index of the stop period for the latched stop setting.
    always_comb begin
        case (stop_q)
            2'd0:    stop_last = BIT_LAST;
            2'd1:    stop_last = STOP15_LAST;
            default: stop_last = STOP2_LAST;
        endcase
    end

    // Frame sequencer: next state, counters, shift register and tx level.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        nbits_d   = nbits_q;
        stop_d    = stop_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        done_tick = 1'b0;
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (accept) begin
                    state_d   = START;
                    bit_d     = '0;
                    shift_d   = din;
                    nbits_d   = nbits_clamp;
                    stop_d    = cfg_stop;
                    par_en_d  = par_en_new;
                    par_bit_d = par_bit_new;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == BIT_LAST) begin
                        state_d = DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == nbits_q - 4'd1) begin
                            state_d = par_en_q ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (tick_q == BIT_LAST) begin
                        state_d = STOP;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_q == stop_last) begin
                        state_d   = IDLE;
                        tick_d    = '0;
                        done_tick = 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
            end
        endcase

        // tx is registered: drive the level belonging to the next state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            nbits_q   <= '0;
            stop_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            nbits_q   <= nbits_d;
            stop_q    <= stop_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
        end
    end

    assign tx           = tx_q;
    assign busy         = (state_q != IDLE);
    // A reset landing on the final stop tick drops the word without a pulse.
    assign tx_done_tick = done_tick && reset_n;

endmodule
